acc_core_param: RTL and testbench



---
 rtl/acc_core_pkg.sv | 37 +++
 rtl/acc_core_param_seq_muldiv.sv | 79 +++++++
 rtl/acc_core_param.sv | 192 +++++++++++++++++++
 tb/tb_acc_core_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_core_pkg.sv
// Shared opcodes, ALU sub-ops and FSM state encoding for the
// parametrised accumulator core.
package acc_core_pkg;

   localparam logic [3:0] OP_ALU0 = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_DIV  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_CMP  = 4'h7;
   localparam logic [3:0] OP_BRC  = 4'h8;
   localparam logic [3:0] OP_MOV  = 4'h9;
   localparam logic [3:0] OP_STA  = 4'hA;
   localparam logic [3:0] OP_RET  = 4'hB;
   localparam logic [3:0] OP_ADC  = 4'hC;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [3:0] SUB_NOP = 4'h0;
   localparam logic [3:0] SUB_SHL = 4'h1;
   localparam logic [3:0] SUB_SHR = 4'h2;
   localparam logic [3:0] SUB_ROR = 4'h3;
   localparam logic [3:0] SUB_ROL = 4'h4;
   localparam logic [3:0] SUB_ASR = 4'h5;
   localparam logic [3:0] SUB_INC = 4'h6;
   localparam logic [3:0] SUB_DEC = 4'h7;
   localparam logic [3:0] SUB_HLT = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/acc_core_param_seq_muldiv.sv
// Sequential unsigned multiplier (shift-add) and restoring divider.
// One iteration per clock; done flags the cycle of the final iteration.
module seq_muldiv #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          done,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo
);

   localparam int CW = $clog2(DW + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] hi_q, hi_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [DW-1:0] b_q, b_d;
   logic          op_q, op_d;
   logic [DW:0]   sum;
   logic [DW:0]   shifted;
   logic          ge;

   always_comb begin
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      op_d    = op_q;
      sum     = '0;
      shifted = '0;
      ge      = 1'b0;
      if (start) begin
         cnt_d = CW'(DW);
         hi_d  = '0;
         lo_d  = a;
         b_d   = b;
         op_d  = op;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         if (!op_q) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            hi_d = sum[DW:1];
            lo_d = {sum[0], lo_q[DW-1:1]};
         end else begin
            // partial remainder gains one dividend bit; subtract only if it fits
            shifted = {hi_q, lo_q[DW-1]};
            ge      = (shifted >= {1'b0, b_q});
            lo_d    = {lo_q[DW-2:0], ge};
            hi_d    = ge ? DW'(shifted - {1'b0, b_q}) : shifted[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         op_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         op_q  <= op_d;
      end
   end

   assign done = (cnt_q == CW'(1));
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/acc_core_param.sv
// Parametrised accumulator core: valid/ready instruction intake, register
// file, single-cycle ALU and multi-cycle MUL/DIV via seq_muldiv.
//
//   state | meaning
//   IDLE  | accepting instructions (unless halted)
//   MUL   | shift-add iterations in progress
//   DIV   | restoring-divide iterations in progress
//   DONE  | write product/quotient back to acc/ext
module acc_core_param
   import acc_core_pkg::*;
#(
   parameter int DW   = 8,
   parameter int NREG = 16,
   parameter int PCW  = 8
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [3:0]     opcode,
   input  logic [3:0]     regaddr,
   output logic [DW-1:0]  acc,
   output logic [DW-1:0]  ext,
   output logic           carry_borrow,
   output logic [PCW-1:0] pc,
   output logic           busy,
   output logic           div_by_zero,
   output logic           halted
);

   localparam int RAW = (NREG > 1) ? $clog2(NREG) : 1;

   state_e         state_q, state_d;
   logic [DW-1:0]  acc_q, acc_d;
   logic [DW-1:0]  ext_q, ext_d;
   logic           cb_q, cb_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic           halted_q, halted_d;
   logic           dbz_q, dbz_d;
   logic           div_q, div_d;
   logic [DW-1:0]  regs_q [NREG];

   logic [RAW-1:0] raddr;
   logic [DW-1:0]  ri;
   logic [PCW-1:0] ri_pc;
   logic           accept;
   logic           reg_we;
   logic           md_start;
   logic           md_op;
   logic           md_done;
   logic [DW-1:0]  md_hi;
   logic [DW-1:0]  md_lo;

   assign raddr       = regaddr[RAW-1:0];
   assign ri          = regs_q[raddr];
   assign ri_pc       = PCW'(ri);
   assign instr_ready = (state_q == IDLE) && !halted_q;
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      ext_d    = ext_q;
      cb_d     = cb_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      dbz_d    = 1'b0;
      div_d    = div_q;
      reg_we   = 1'b0;
      md_start = 1'b0;
      md_op    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               pc_d = pc_q + PCW'(1);
               case (opcode)
                  OP_ALU0: begin
                     case (regaddr)
                        SUB_SHL: acc_d = acc_q << 1;
                        SUB_SHR: acc_d = acc_q >> 1;
                        SUB_ROR: acc_d = {acc_q[0], acc_q[DW-1:1]};
                        SUB_ROL: acc_d = {acc_q[DW-2:0], acc_q[DW-1]};
                        SUB_ASR: acc_d = {acc_q[DW-1], acc_q[DW-1:1]};
                        SUB_INC: {cb_d, acc_d} = {1'b0, acc_q} + (DW+1)'(1);
                        SUB_DEC: begin
                           acc_d = acc_q - DW'(1);
                           cb_d  = (acc_q == '0);
                        end
                        default: ;
                     endcase
                  end
                  OP_ADD: {cb_d, acc_d} = {1'b0, acc_q} + {1'b0, ri};
                  OP_ADC: {cb_d, acc_d} = {1'b0, acc_q} + {1'b0, ri} + (DW+1)'(cb_q);
                  OP_SUB: begin
                     acc_d = acc_q - ri;
                     cb_d  = (acc_q < ri);
                  end
                  OP_MUL: begin
                     md_start = 1'b1;
                     div_d    = 1'b0;
                     state_d  = MUL;
                  end
                  OP_DIV: begin
                     // zero divisor resolves in one cycle, never enters DIV
                     if (ri == '0) begin
                        acc_d = '1;
                        ext_d = acc_q;
                        cb_d  = 1'b1;
                        dbz_d = 1'b1;
                     end else begin
                        md_start = 1'b1;
                        md_op    = 1'b1;
                        div_d    = 1'b1;
                        state_d  = DIV;
                     end
                  end
                  OP_AND: acc_d = acc_q & ri;
                  OP_XOR: acc_d = acc_q ^ ri;
                  OP_CMP: cb_d = (acc_q < ri);
                  OP_BRC: if (cb_q) pc_d = ri_pc;
                  OP_MOV: acc_d = ri;
                  OP_STA: reg_we = 1'b1;
                  OP_RET: pc_d = ri_pc;
                  OP_HLT: if (regaddr == SUB_HLT) halted_d = 1'b1;
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (md_done) state_d = DONE;
         end
         DONE: begin
            acc_d   = md_lo;
            ext_d   = md_hi;
            if (div_q) cb_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         ext_q    <= '0;
         cb_q     <= 1'b0;
         pc_q     <= '0;
         halted_q <= 1'b0;
         dbz_q    <= 1'b0;
         div_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ext_q    <= ext_d;
         cb_q     <= cb_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         dbz_q    <= dbz_d;
         div_q    <= div_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= DW'(i);
      end else if (reg_we) begin
         regs_q[raddr] <= acc_q;
      end
   end

   seq_muldiv #(.DW(DW)) u_muldiv (
      .clk   (clk),
      .rstn  (rstn),
      .start (md_start),
      .op    (md_op),
      .a     (acc_q),
      .b     (ri),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   assign acc          = acc_q;
   assign ext          = ext_q;
   assign carry_borrow = cb_q;
   assign pc           = pc_q;
   assign busy         = (state_q != IDLE);
   assign div_by_zero  = dbz_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_acc_core_param.sv
// Directed bench for acc_core_param (DW=8, NREG=16, PCW=8) with
// hand-computed expected values.
module tb_acc_core_param;

   logic       clk = 1'b0;
   logic       rstn;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] opcode;
   logic [3:0] regaddr;
   logic [7:0] acc;
   logic [7:0] ext;
   logic       carry_borrow;
   logic [7:0] pc;
   logic       busy;
   logic       div_by_zero;
   logic       halted;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   acc_core_param #(.DW(8), .NREG(16), .PCW(8)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .opcode       (opcode),
      .regaddr      (regaddr),
      .acc          (acc),
      .ext          (ext),
      .carry_borrow (carry_borrow),
      .pc           (pc),
      .busy         (busy),
      .div_by_zero  (div_by_zero),
      .halted       (halted)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // drive one instruction for one accepting edge, sample at the next negedge
   task automatic exec(input logic [3:0] op, input logic [3:0] ra);
      @(negedge clk);
      instr_valid = 1'b1;
      opcode      = op;
      regaddr     = ra;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   logic [7:0] pc_hold, acc_hold;

   initial begin
      rstn        = 1'b0;
      instr_valid = 1'b0;
      opcode      = 4'h0;
      regaddr     = 4'h0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_acc", acc, 8'h00);
      chk("rst_ext", ext, 8'h00);
      chk("rst_cb", carry_borrow, 1'b0);
      chk("rst_pc", pc, 8'h00);
      chk("rst_ready", instr_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_halt", halted, 1'b0);

      exec(4'h9, 4'd5);
      chk("mov_acc", acc, 8'h05);
      chk("mov_pc", pc, 8'h01);

      exec(4'h9, 4'd0);
      exec(4'h0, 4'd7);
      chk("dec_acc", acc, 8'hFF);
      chk("dec_cb", carry_borrow, 1'b1);
      exec(4'h0, 4'd6);
      chk("inc_acc", acc, 8'h00);
      chk("inc_cb", carry_borrow, 1'b1);
      exec(4'hC, 4'd3);
      chk("adc_acc", acc, 8'h04);
      chk("adc_cb", carry_borrow, 1'b0);
      exec(4'h2, 4'd5);
      chk("sub_acc", acc, 8'hFF);
      chk("sub_cb", carry_borrow, 1'b1);
      chk("sub_pc", pc, 8'h06);

      // MUL 0xFF * R15; a held valid during busy must not be taken
      @(negedge clk);
      instr_valid = 1'b1;
      opcode      = 4'h3;
      regaddr     = 4'd15;
      @(posedge clk);
      @(negedge clk);
      opcode  = 4'h9;
      regaddr = 4'd0;
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("mul_busy%0d", k), busy, 1'b1);
         chk($sformatf("mul_rdy%0d", k), instr_ready, 1'b0);
         if (k < 9) @(negedge clk);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      chk("mul_busy_end", busy, 1'b0);
      chk("mul_acc", acc, 8'hF1);
      chk("mul_ext", ext, 8'h0E);
      chk("mul_cb", carry_borrow, 1'b1);
      chk("mul_pc", pc, 8'h07);

      exec(4'h9, 4'd9);
      exec(4'h4, 4'd4);
      wait_idle("div_timeout");
      chk("div_acc", acc, 8'h02);
      chk("div_ext", ext, 8'h01);
      chk("div_cb", carry_borrow, 1'b0);

      exec(4'h9, 4'd9);
      exec(4'h4, 4'd0);
      chk("dbz_acc", acc, 8'hFF);
      chk("dbz_ext", ext, 8'h09);
      chk("dbz_cb", carry_borrow, 1'b1);
      chk("dbz_pulse", div_by_zero, 1'b1);
      chk("dbz_busy", busy, 1'b0);
      @(negedge clk);
      chk("dbz_clear", div_by_zero, 1'b0);
      chk("dbz_pc", pc, 8'h0B);

      exec(4'h9, 4'd3);
      exec(4'h7, 4'd5);
      chk("cmp_lt", carry_borrow, 1'b1);
      chk("cmp_acc", acc, 8'h03);
      exec(4'h8, 4'd12);
      chk("brc_taken", pc, 8'h0C);
      exec(4'h7, 4'd2);
      chk("cmp_ge", carry_borrow, 1'b0);
      exec(4'h8, 4'd12);
      chk("brc_not", pc, 8'h0E);
      exec(4'hB, 4'd7);
      chk("ret_pc", pc, 8'h07);

      exec(4'h9, 4'd9);
      exec(4'hA, 4'd2);
      exec(4'h9, 4'd0);
      exec(4'h9, 4'd2);
      chk("sta_mov", acc, 8'h09);
      exec(4'h1, 4'd15);
      chk("add_acc", acc, 8'h18);
      chk("add_cb", carry_borrow, 1'b0);
      exec(4'h9, 4'd15);
      exec(4'h0, 4'd4);
      chk("rol", acc, 8'h1E);
      exec(4'h0, 4'd3);
      chk("ror", acc, 8'h0F);
      exec(4'h0, 4'd2);
      chk("shr", acc, 8'h07);
      exec(4'h0, 4'd1);
      chk("shl", acc, 8'h0E);
      exec(4'h9, 4'd12);
      exec(4'h6, 4'd10);
      chk("xor", acc, 8'h06);
      exec(4'h5, 4'd7);
      chk("and", acc, 8'h06);
      chk("pc_pre_hlt", pc, 8'h14);

      exec(4'hF, 4'hF);
      chk("hlt_flag", halted, 1'b1);
      chk("hlt_ready", instr_ready, 1'b0);
      pc_hold  = pc;
      acc_hold = acc;
      chk("hlt_pc", pc_hold, 8'h15);
      @(negedge clk);
      instr_valid = 1'b1;
      opcode      = 4'h0;
      regaddr     = 4'd6;
      repeat (5) @(negedge clk);
      instr_valid = 1'b0;
      chk("hlt_pc_frozen", pc, 8'h15);
      chk("hlt_acc_frozen", acc, acc_hold);

      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst2_halt", halted, 1'b0);
      exec(4'h9, 4'd5);
      exec(4'h3, 4'd3);
      repeat (3) @(negedge clk);
      chk("abort_busy_pre", busy, 1'b1);
      rstn = 1'b0;
      #1;
      chk("abort_acc", acc, 8'h00);
      chk("abort_ext", ext, 8'h00);
      chk("abort_pc", pc, 8'h00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_cb", carry_borrow, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("abort_ready", instr_ready, 1'b1);
      repeat (12) @(negedge clk);
      chk("abort_no_wb", acc, 8'h00);
      chk("abort_ext_wb", ext, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
